chain_latency_meter: RTL and testbench

Stimulus-and-capture stage around the 8-lane delay-chain macro. It drives the chain's lane inputs with a primed bit pattern, launches its complement, and resynchronises the chain's lane outputs. It reports the clock-cycle latency until every lane has flipped, or a timeout with the lanes that never arrived. It connects directly to the chain's data inputs and consumes the chain's data outputs.

---
 rtl/chain_meter_pkg.sv | 18 +
 rtl/lane_sync.sv | 30 +++
 rtl/chain_latency_meter.sv | 182 ++++++++++++++++++
 tb/tb_chain_latency_meter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/chain_meter_pkg.sv
// Shared types and constants for the delay-chain latency meter.
// Optional per-lane latency output is enabled by CHAIN_METER_LANE_LAT_EN.
package chain_meter_pkg;

  localparam int SYNC_STAGES = 2;
  localparam int DEF_LANES   = 8;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_TIMEOUT = 4095;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_LAUNCH,
    ST_MEASURE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/lane_sync.sv
// Multi-flop resynchroniser for the asynchronous chain lane outputs.
// Async active-high reset to zero.
module lane_sync
  import chain_meter_pkg::*;
#(
  parameter int WIDTH  = DEF_LANES,
  parameter int STAGES = SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] ff_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff_q <= '0;
    end else begin
      ff_q[0] <= d_i;
      for (int s = 1; s < STAGES; s++) begin
        ff_q[s] <= ff_q[s-1];
      end
    end
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/chain_latency_meter.sv
// Primes, launches and times a pattern through the 8-lane delay chain.
// Define CHAIN_METER_LANE_LAT_EN to add the per-lane lane_latency output.
module chain_latency_meter
  import chain_meter_pkg::*;
#(
  parameter int LANES   = DEF_LANES,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LANES-1:0] pattern,
  output logic [LANES-1:0] chain_din,
  input  logic [LANES-1:0] chain_dout,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] latency,
`ifdef CHAIN_METER_LANE_LAT_EN
  output logic [LANES*CNT_W-1:0] lane_latency,
`endif
  output logic [LANES-1:0] missing
);

  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_e           state_q, state_d;
  logic [LANES-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LANES-1:0] din_q, din_d;
  logic [LANES-1:0] seen_q, seen_d;
  logic [CNT_W-1:0] lat_q, lat_d;
  logic             to_q, to_d;
  logic [LANES-1:0] miss_q, miss_d;
  logic [LANES-1:0] dsync;
  logic [LANES-1:0] seen_nx;
  logic [CNT_W-1:0] cnt_inc;

`ifdef CHAIN_METER_LANE_LAT_EN
  logic [LANES-1:0][CNT_W-1:0] llat_q, llat_d;
`endif

  lane_sync #(
    .WIDTH (LANES),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d_i(chain_dout),
    .q_o(dsync)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      cnt_q   <= '0;
      din_q   <= '0;
      seen_q  <= '0;
      lat_q   <= '0;
      to_q    <= 1'b0;
      miss_q  <= '0;
`ifdef CHAIN_METER_LANE_LAT_EN
      llat_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      seen_q  <= seen_d;
      lat_q   <= lat_d;
      to_q    <= to_d;
      miss_q  <= miss_d;
`ifdef CHAIN_METER_LANE_LAT_EN
      llat_q  <= llat_d;
`endif
    end
  end

  // Lanes count as arrived once they match the launched value; sticky.
  assign seen_nx = seen_q | ~(dsync ^ pat_q);
  assign cnt_inc = cnt_q + ONE;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    seen_d  = seen_q;
    lat_d   = lat_q;
    to_d    = to_q;
    miss_d  = miss_q;
`ifdef CHAIN_METER_LANE_LAT_EN
    llat_d  = llat_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          pat_d   = pattern;
          cnt_d   = '0;
          din_d   = ~pattern;
          to_d    = 1'b0;
`ifdef CHAIN_METER_LANE_LAT_EN
          llat_d  = '0;
`endif
          state_d = ST_PRIME;
        end
      end
      ST_PRIME: begin
        cnt_d = cnt_inc;
        if (dsync == ~pat_q) begin
          cnt_d   = '0;
          state_d = ST_LAUNCH;
        end else if (cnt_inc == TO_LIM) begin
          to_d    = 1'b1;
          miss_d  = '1;
`ifdef CHAIN_METER_LANE_LAT_EN
          llat_d  = '1;
`endif
          state_d = ST_DONE;
        end
      end
      ST_LAUNCH: begin
        din_d   = pat_q;
        cnt_d   = '0;
        seen_d  = '0;
        state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        cnt_d  = cnt_inc;
        seen_d = seen_nx;
`ifdef CHAIN_METER_LANE_LAT_EN
        for (int i = 0; i < LANES; i++) begin
          if (seen_nx[i] && !seen_q[i]) begin
            llat_d[i] = cnt_q;
          end
        end
`endif
        if (&seen_nx) begin
          lat_d   = cnt_q;
          to_d    = 1'b0;
          miss_d  = '0;
          state_d = ST_DONE;
        end else if (cnt_inc == TO_LIM) begin
          to_d    = 1'b1;
          miss_d  = ~seen_nx;
`ifdef CHAIN_METER_LANE_LAT_EN
          for (int i = 0; i < LANES; i++) begin
            if (!seen_nx[i]) begin
              llat_d[i] = '1;
            end
          end
`endif
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign chain_din = din_q;
  assign busy      = (state_q == ST_PRIME)  ||
                     (state_q == ST_LAUNCH) ||
                     (state_q == ST_MEASURE);
  assign done      = (state_q == ST_DONE);
  assign timeout   = to_q;
  assign latency   = lat_q;
  assign missing   = miss_q;

`ifdef CHAIN_METER_LANE_LAT_EN
  assign lane_latency = llat_q;
`endif

endmodule

// File: tb/tb_chain_latency_meter.sv
// Directed bench for chain_latency_meter with a behavioural chain model.
// Build with CHAIN_METER_LANE_LAT_EN to also exercise lane_latency.
module tb_chain_latency_meter;

  localparam int L  = 8;
  localparam int W  = 16;
  localparam int TO = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [L-1:0] pattern = '0;
  logic [L-1:0] chain_din;
  logic [L-1:0] chain_dout;
  logic         busy;
  logic         done;
  logic         timeout;
  logic [W-1:0] latency;
  logic [L-1:0] missing;
`ifdef CHAIN_METER_LANE_LAT_EN
  logic [L*W-1:0] lane_latency;
`endif

  int nvec = 0;
  int nerr = 0;
  int mode = 0;

  always #5 clk = ~clk;

  chain_latency_meter #(
    .LANES  (L),
    .CNT_W  (W),
    .TIMEOUT(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pattern   (pattern),
    .chain_din (chain_din),
    .chain_dout(chain_dout),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .latency   (latency),
`ifdef CHAIN_METER_LANE_LAT_EN
    .lane_latency(lane_latency),
`endif
    .missing   (missing)
  );

  // sr[k] is chain_din delayed by k+1 clocks
  logic [L-1:0] sr [16];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) sr[k] <= '0;
    end else begin
      sr[0] <= chain_din;
      for (int k = 1; k < 16; k++) sr[k] <= sr[k-1];
    end
  end

  always_comb begin
    chain_dout = chain_din;
    case (mode)
      1: chain_dout = sr[6];
      2: chain_dout = chain_din & 8'hF7;
      3: chain_dout = chain_din | 8'h01;
      4: for (int i = 0; i < L; i++) chain_dout[i] = sr[2+i][i];
      default: chain_dout = chain_din;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run(input logic [L-1:0] p, output int bcyc,
                     output int ndone, output bit gap,
                     output logic [L-1:0] din0);
    @(negedge clk);
    pattern = p;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    bcyc  = 0;
    ndone = 0;
    gap   = 1'b0;
    din0  = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c == 0) din0 = chain_din;
      if (done) begin
        ndone++;
        break;
      end
      if (busy) bcyc++;
      else gap = 1'b1;
    end
  endtask

  int           bc;
  int           nd;
  bit           gp;
  logic [L-1:0] d0;

  initial begin
    #1 rst = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_din", chain_din, 0);
    check("rst_lat", latency, 0);
    check("rst_to", timeout, 0);
    check("rst_miss", missing, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    mode = 0;
    run(8'hA5, bc, nd, gp, d0);
    check("wire_prime_din", d0, 8'h5A);
    check("wire_done", nd, 1);
    check("wire_busy_cyc", bc, 7);
    check("wire_gap", gp, 0);
    check("wire_lat", latency, 2);
    check("wire_to", timeout, 0);
    check("wire_miss", missing, 0);
    check("wire_din", chain_din, 8'hA5);
    @(negedge clk);
    check("wire_done_pulse", done, 0);

    mode = 1;
    run(8'hFF, bc, nd, gp, d0);
    check("ch7_done", nd, 1);
    check("ch7_busy_cyc", bc, 21);
    check("ch7_gap", gp, 0);
    check("ch7_lat", latency, 9);
    check("ch7_to", timeout, 0);

    mode = 2;
    run(8'h08, bc, nd, gp, d0);
    check("stk3_done", nd, 1);
    check("stk3_to", timeout, 1);
    check("stk3_miss", missing, 8'h08);
    check("stk3_lat", latency, 9);

    mode = 3;
    run(8'h01, bc, nd, gp, d0);
    check("stk0_done", nd, 1);
    check("stk0_busy_cyc", bc, TO);
    check("stk0_to", timeout, 1);
    check("stk0_miss", missing, 8'hFF);
    check("stk0_lat", latency, 9);

    mode = 1;
    nd = 0;
    @(negedge clk);
    pattern = 8'h3C;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c == 14) start = 1'b1;
      if (c == 15) start = 1'b0;
      if (done) nd++;
    end
    check("repulse_ndone", nd, 1);
    check("repulse_lat", latency, 9);
    check("repulse_busy", busy, 0);

    @(negedge clk);
    pattern = 8'h3C;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (14) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_din", chain_din, 0);
    check("mid_rst_lat", latency, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(8'h3C, bc, nd, gp, d0);
    check("post_rst_done", nd, 1);
    check("post_rst_busy_cyc", bc, 21);
    check("post_rst_lat", latency, 9);
    check("post_rst_to", timeout, 0);

`ifdef CHAIN_METER_LANE_LAT_EN
    repeat (20) @(negedge clk);
    mode = 4;
    run(8'h3C, bc, nd, gp, d0);
    check("llat_done", nd, 1);
    check("llat_lat", latency, 12);
    check("llat_to", timeout, 0);
    for (int i = 0; i < L; i++) begin
      check($sformatf("llat_lane%0d", i), lane_latency[i*W +: W], 5 + i);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
